md_unit_iter: RTL and testbench
===============================

// Module: md_unit_iter
// PURPOSE
//   Parametrised multiply/divide unit with HI/LO result registers for the E stage of the pipelined CPU.
//   Multiply results appear after a configurable fixed latency.
//   Divide is a real iterative restoring divider: one quotient bit per cycle.
//   Adds multiply-accumulate (MADD/MADDU/MSUB/MSUBU) and a divide-by-zero indication.
//   busy drives the stall unit; req (exception/interrupt flush) blocks issue of new operations.
// PARAMETERS
//   WIDTH    32  operand / HI / LO width in bits (>=4)
//   MUL_LAT  5   cycles busy stays high for MULT/MULTU/MADD*/MSUB* (>=1)
//   DIV_LAT  (localparam) = WIDTH+1; cycles busy stays high for DIV/DIVU
// PORTS
//   clk       in   1      clock, all state updates on rising edge
//   reset     in   1      synchronous, active-high
//   src_a     in   WIDTH  operand A (dividend / MT source)
//   src_b     in   WIDTH  operand B (divisor)
//   op        in   4      0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,6 madd,7 maddu,8 msub,9 msubu, other none
//   start     in   1      issue op this cycle
//   req       in   1      flush: any start this cycle is ignored
//   busy      out  1      operation in flight; HI/LO not yet valid
//   hi        out  WIDTH  architectural HI
//   lo        out  WIDTH  architectural LO
//   done      out  1      one-cycle pulse on the cycle after HI/LO are written by a mul/div op
//   div_zero  out  1      one-cycle pulse with done when the divide had src_b==0
// BEHAVIOUR
// - Reset
//   - busy=0, hi=lo=0, done=0, div_zero=0, state IDLE.
//   - Reset mid-operation abandons it; HI/LO reset to 0.
// - Issue
//   - Accepted only at an edge where state==IDLE && start && !req. Otherwise start is ignored, with no queueing.
//   - start while busy is ignored; the stall unit must prevent this.
// - MTHI/MTLO: on accept, hi<=src_a (or lo<=src_a) at that edge. busy stays 0, no done pulse.
// - Op "none" with start: no effect.
// - States
//   - IDLE -> MUL on accept of a mul-class op: signed/unsigned 2*WIDTH product latched at the accept edge; counter=MUL_LAT.
//   - IDLE -> DIV on accept of div/divu: |a|, |b| (or raw values for divu) and the result signs latched; counter=WIDTH.
//   - MUL: counter decrements each edge. At the edge where counter==1, write results and go to IDLE:
//     - mult/multu: {hi,lo} <= product
//     - madd*: {hi,lo} <= {hi,lo} + product
//     - msub*: {hi,lo} <= {hi,lo} - product
//     - Accumulate arithmetic is mod 2^(2*WIDTH).
//   - DIV: one restoring shift-subtract step per edge for WIDTH edges, then FIX.
//   - FIX: one edge; apply signs and write results, then IDLE.
//     - Quotient is truncated toward zero; remainder takes the sign of the dividend.
//     - lo<=quotient, hi<=remainder.
//     - If src_b was 0: hi/lo unchanged, div_zero pulses. Still takes full DIV_LAT.
//     - Signed MIN/-1: lo=MIN (wrap), hi=0.
// - busy
//   - 1 from the edge after accept until the writing edge. High for exactly MUL_LAT or DIV_LAT cycles.
//   - busy falls at the same edge hi/lo update.
//   - done (and div_zero) are registered, high for exactly the following cycle.
// - req
//   - Affects only issue.
//   - An op already in flight completes normally (it was committed before the flush).
//   - req and start in the same cycle: not accepted, no state change.
// - hi/lo change only on reset, MT accept, or completion. Never during busy.
// TESTING (WIDTH=32, MUL_LAT=5)
//   1. mult a=FFFFFFFF b=00000002 -> busy 5 cycles; hi=FFFFFFFF lo=FFFFFFFE; done 1 cycle; multu same operands -> hi=00000001 lo=FFFFFFFE
//   2. div a=FFFFFFF9(-7) b=2 -> busy 33 cycles, lo=FFFFFFFD hi=FFFFFFFF; divu 7/2 -> lo=3 hi=1
//   3. mthi 5, mtlo 9, then div b=0 -> after 33 cycles hi=5 lo=9, div_zero and done pulse together
//   4. mtlo FFFFFFFF, mthi 0, maddu 1*1 -> hi=1 lo=0; then msub 1*2 -> hi=0 lo=FFFFFFFE
//   5. start mult with req=1 -> busy stays 0, hi/lo unchanged; reset asserted mid-div (cycle 10) -> busy=0, hi=lo=0 next cycle
//   6. div a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000; back-to-back start on the cycle after busy falls is accepted

Source files
------------

// File: rtl/md_unit_iter.sv
// Multiply/divide unit with HI/LO registers: fixed-latency multiply (with accumulate)
// and an iterative restoring divider producing one quotient bit per cycle.
module md_unit_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int W2      = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

  state_t            state_q, state_d;
  acc_t              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d, divz_q, divz_d;
  logic [W2-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic              negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

  logic signed [W2-1:0] a_sx, b_sx, prod_s;
  logic        [W2-1:0] prod_u, hl_cur, hl_new;
  logic        [WIDTH:0] trial;
  logic                  accept;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign a_sx   = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a});
  assign b_sx   = $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
  assign hl_cur = {hi_q, lo_q};
  assign trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign accept = start && !req;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    divz_d  = 1'b0;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hl_new  = prod_q;
    case (acc_q)
      ACC_ADD: hl_new = hl_cur + prod_q;
      ACC_SUB: hl_new = hl_cur - prod_q;
      default: hl_new = prod_q;
    endcase
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9: begin
              prod_d  = (op == 4'd0 || op == 4'd6 || op == 4'd8) ? prod_s : prod_u;
              acc_d   = (op == 4'd6 || op == 4'd7) ? ACC_ADD :
                        (op == 4'd8 || op == 4'd9) ? ACC_SUB : ACC_NONE;
              cnt_d   = CNT_W'(MUL_LAT);
              state_d = S_MUL;
            end
            4'd2: begin
              quo_d   = abs_val(src_a);
              dvs_d   = abs_val(src_b);
              negq_d  = src_a[WIDTH-1] ^ src_b[WIDTH-1];
              negr_d  = src_a[WIDTH-1];
              rem_d   = '0;
              dz_d    = (src_b == '0);
              cnt_d   = CNT_W'(WIDTH);
              state_d = S_DIV;
            end
            4'd3: begin
              quo_d   = src_a;
              dvs_d   = src_b;
              negq_d  = 1'b0;
              negr_d  = 1'b0;
              rem_d   = '0;
              dz_d    = (src_b == '0);
              cnt_d   = CNT_W'(WIDTH);
              state_d = S_DIV;
            end
            4'd4:    hi_d = src_a;
            4'd5:    lo_d = src_a;
            default: ;
          endcase
        end
      end
      // Multiply: product already formed, just count out the latency
      S_MUL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          {hi_d, lo_d} = hl_new;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end
      // Restoring step: keep the trial remainder only if it did not go negative
      S_DIV: begin
        cnt_d = cnt_q - 1'b1;
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q) begin
          divz_d = 1'b1;
        end else begin
          lo_d = neg_if(quo_q, negq_q);
          hi_d = neg_if(rem_q, negr_q);
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    prod_q <= prod_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
    dz_q   <= dz_d;
  end

  assign busy     = (state_q != S_IDLE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = divz_q;

endmodule

// File: tb/tb_md_unit_iter.sv
// Directed bench for md_unit_iter: a table of ops with hand-computed HI/LO and
// latency, plus sequences for flush, back-to-back issue and reset mid-divide.
module tb_md_unit_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_a, src_b;
  logic [3:0]  op;
  logic        start, req;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  md_unit_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk(clk), .reset(reset), .src_a(src_a), .src_b(src_b), .op(op),
    .start(start), .req(req), .busy(busy), .hi(hi), .lo(lo),
    .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          elat;
    logic        edone;
    logic        edz;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    while (busy && lat < 200) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    @(negedge clk);
    op = tv[i].op; src_a = tv[i].a; src_b = tv[i].b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(lat);
    chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tv[i].elat));
    chk($sformatf("v%0d_hi", i), 64'(hi), 64'(tv[i].ehi));
    chk($sformatf("v%0d_lo", i), 64'(lo), 64'(tv[i].elo));
    chk($sformatf("v%0d_done", i), 64'(done), 64'(tv[i].edone));
    chk($sformatf("v%0d_dz", i), 64'(div_zero), 64'(tv[i].edz));
    @(negedge clk);
    chk($sformatf("v%0d_done_drop", i), 64'({done, div_zero}), 64'd0);
  endtask

  initial begin
    int lat;
    tv[0]  = '{4'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5,  1'b1, 1'b0};
    tv[1]  = '{4'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5,  1'b1, 1'b0};
    tv[2]  = '{4'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1, 1'b0};
    tv[3]  = '{4'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33, 1'b1, 1'b0};
    tv[4]  = '{4'd4, 32'h00000005, 32'h00000000, 32'h00000005, 32'h00000003, 0,  1'b0, 1'b0};
    tv[5]  = '{4'd5, 32'h00000009, 32'h00000000, 32'h00000005, 32'h00000009, 0,  1'b0, 1'b0};
    tv[6]  = '{4'd2, 32'h00001234, 32'h00000000, 32'h00000005, 32'h00000009, 33, 1'b1, 1'b1};
    tv[7]  = '{4'd5, 32'hFFFFFFFF, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 0,  1'b0, 1'b0};
    tv[8]  = '{4'd4, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0,  1'b0, 1'b0};
    tv[9]  = '{4'd7, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 5,  1'b1, 1'b0};
    tv[10] = '{4'd8, 32'h00000001, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 5,  1'b1, 1'b0};
    tv[11] = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1, 1'b0};
    tv[12] = '{4'd6, 32'hFFFFFFFF, 32'h00000003, 32'h00000000, 32'h7FFFFFFD, 5,  1'b1, 1'b0};
    tv[13] = '{4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFC, 5,  1'b1, 1'b0};
    tv[14] = '{4'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b1, 1'b0};
    tv[15] = '{4'd15, 32'h12345678, 32'h00000001, 32'h00000001, 32'hFFFFFFFD, 0, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; req = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {28'd0, busy, done, div_zero, 1'b0, hi, lo}, 64'd0);

    for (int i = 0; i < 16; i++) run_vec(i);

    // Flush in the same cycle as start: nothing issues
    @(negedge clk);
    op = 4'd0; src_a = 32'h00000003; src_b = 32'h00000004; start = 1'b1; req = 1'b1;
    @(negedge clk);
    start = 1'b0; req = 1'b0;
    chk("req_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    chk("req_hilo", {hi, lo}, {32'h00000001, 32'hFFFFFFFD});
    chk("req_done", 64'(done), 64'd0);

    // Back-to-back: start multu on the first cycle busy is low again
    op = 4'd3; src_a = 32'd7; src_b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(lat);
    chk("b2b_div_lat", 64'(lat), 64'd33);
    op = 4'd1; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept", 64'(busy), 64'd1);
    wait_idle(lat);
    chk("b2b_mul_lat", 64'(lat), 64'd5);
    chk("b2b_hilo", {hi, lo}, {32'h00000000, 32'h0000000C});

    // Reset during a divide abandons it and clears HI/LO
    @(negedge clk);
    op = 4'd2; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("middiv_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    repeat (30) @(negedge clk);
    chk("rst_mid_after", {30'd0, busy, done, hi}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
